// File: rtl/arp_replay_switch_if.sv
// arp_replay_switch_if: GMII-style byte stream (data, valid, error)
interface arp_replay_switch_if;
    logic [7:0] data;
    logic       dv;
    logic       er;
    modport master(output data, dv, er);
    modport slave(input data, dv, er);
endinterface

// File: rtl/arp_replay_switch.sv
// arp_replay_switch: GMII pass-through that captures the latest good ARP frame
// and replays it after a path switch or trigger so peers relearn the path.
module arp_replay_switch #(
    parameter int          CAP_DEPTH    = 128,
    parameter int          MATCH_OFFSET = 20,
    parameter logic [15:0] MATCH_TYPE   = 16'h0806,
    parameter int          REPEAT       = 3,
    parameter int          IFG_CLOCKS   = 128
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       select,
    input  logic                       trig,
    arp_replay_switch_if.slave         up,
    arp_replay_switch_if.master        down,
    output logic                       busy,
    output logic                       captured,
    output logic                       replay_done,
    output logic [15:0]                drop_cnt
);
    localparam int AW = $clog2(CAP_DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(CAP_DEPTH);
    typedef enum logic [2:0] {PASS, WAIT, FETCH, LAT, DATA, GAP, DRAIN} state_t;
    state_t state;
    logic [7:0] mem [2*CAP_DEPTH];
    logic [7:0] rd_q;
    logic select_q, dv_q, pending, active, rd_slot;
    logic ovf, err, m_hi, m_lo;
    logic [AW:0] cnt, cap_len, rd_len, sent, off, rd_addr;
    logic [AW-1:0] rd_ptr;
    logic [15:0] gap;
    logic [3:0] frames;
    logic rise, fall, commit, leave, in_burst;
    always_comb begin
        rise = up.dv && !dv_q;
        fall = !up.dv && dv_q;
        off = rise ? '0 : cnt;
        commit = fall && m_hi && m_lo && !ovf && !err && !busy;
        leave = state == PASS && pending && captured;
        in_burst = !(state inside {PASS, WAIT});
        rd_addr = state == FETCH ? {active, {AW{1'b0}}} : {rd_slot, rd_ptr};
    end
    // Writer fills the inactive slot; a burst only ever reads the active one.
    always_ff @(posedge clk) begin
        if (up.dv && off != FULL) mem[{~active, off[AW-1:0]}] <= up.data;
        rd_q <= mem[rd_addr];
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= PASS;
            down.data <= '0;
            down.dv <= 1'b0;
            down.er <= 1'b0;
            busy <= 1'b0;
            captured <= 1'b0;
            replay_done <= 1'b0;
            drop_cnt <= '0;
            select_q <= select;
            dv_q <= 1'b0;
            pending <= 1'b0;
            active <= 1'b0;
            cnt <= '0;
            cap_len <= '0;
            ovf <= 1'b0;
            err <= 1'b0;
            m_hi <= 1'b0;
            m_lo <= 1'b0;
            rd_slot <= 1'b0;
            rd_len <= '0;
            rd_ptr <= '0;
            sent <= '0;
            gap <= '0;
            frames <= '0;
        end else begin
            select_q <= select;
            dv_q <= up.dv;
            pending <= (select != select_q) || trig || (pending && !leave);
            replay_done <= 1'b0;
            if (rise && in_burst && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 1'b1;
            if (up.dv) begin
                cnt <= off == FULL ? off : off + 1'b1;
                ovf <= (ovf && !rise) || off == FULL;
                err <= (err && !rise) || up.er;
                m_hi <= (m_hi && !rise) || (int'(off) == MATCH_OFFSET && up.data == MATCH_TYPE[15:8]);
                m_lo <= (m_lo && !rise) || (int'(off) == MATCH_OFFSET + 1 && up.data == MATCH_TYPE[7:0]);
            end
            if (commit) begin
                active <= ~active;
                cap_len <= cnt;
                captured <= 1'b1;
            end
            case (state)
                PASS, WAIT: begin
                    down.data <= up.data;
                    down.dv <= up.dv;
                    down.er <= up.er;
                    // The upstream frame in flight always completes before a burst.
                    if (state == WAIT ? !up.dv : leave) begin
                        state <= up.dv ? WAIT : FETCH;
                        busy <= 1'b1;
                    end
                end
                FETCH: begin
                    rd_slot <= active;
                    rd_len <= cap_len;
                    rd_ptr <= AW'(1);
                    frames <= frames + 1'b1;
                    down.data <= '0;
                    down.dv <= 1'b0;
                    down.er <= 1'b0;
                    state <= LAT;
                end
                LAT: begin
                    down.data <= rd_q;
                    down.dv <= 1'b1;
                    rd_ptr <= rd_ptr + 1'b1;
                    sent <= (AW+1)'(1);
                    state <= DATA;
                end
                DATA: begin
                    if (sent == rd_len) begin
                        down.dv <= 1'b0;
                        gap <= '0;
                        state <= GAP;
                    end else begin
                        down.data <= rd_q;
                        down.dv <= 1'b1;
                        sent <= sent + 1'b1;
                        rd_ptr <= rd_ptr + 1'b1;
                    end
                end
                GAP: begin
                    if (gap == 16'(IFG_CLOCKS - 1)) begin
                        if (frames == 4'(REPEAT)) begin
                            replay_done <= 1'b1;
                            frames <= '0;
                            state <= DRAIN;
                        end else state <= FETCH;
                    end else gap <= gap + 1'b1;
                end
                DRAIN: begin
                    down.dv <= 1'b0;
                    if (!up.dv) begin
                        state <= PASS;
                        busy <= 1'b0;
                    end
                end
                default: state <= PASS;
            endcase
        end
    end
endmodule

// File: tb/tb_arp_replay_switch.sv
// tb_arp_replay_switch: directed stimulus with a byte scoreboard checked by a
// separate monitor against expected data, error flag and arrival cycle.
module tb_arp_replay_switch;
    localparam int DEPTH = 128;
    localparam int IFG = 128;
    localparam int REP = 3;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic select = 1'b0;
    logic trig = 1'b0;
    logic busy, captured, replay_done;
    logic [15:0] drop_cnt;
    arp_replay_switch_if up();
    arp_replay_switch_if down();
    arp_replay_switch dut (
        .clk(clk), .rst(rst), .select(select), .trig(trig), .up(up), .down(down),
        .busy(busy), .captured(captured), .replay_done(replay_done), .drop_cnt(drop_cnt)
    );
    typedef struct {logic [7:0] data; logic er; int cyc;} exp_t;
    exp_t exp_q[$];
    exp_t me;
    int cyc = 0;
    int total = 0;
    int bad = 0;
    int k, s, d1, s2;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (down.dv === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_byte: got %h at cycle %0d, required no output", down.data, cyc);
            end else begin
                me = exp_q.pop_front();
                if (down.data !== me.data || down.er !== me.er || cyc != me.cyc) begin
                    bad++;
                    $display("FAIL byte: got %h er=%b cycle %0d, required %h er=%b cycle %0d",
                             down.data, down.er, cyc, me.data, me.er, me.cyc);
                end
            end
        end
    end
    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish, total=%0d", total);
        $fatal(1);
    end
    task automatic step;
        @(posedge clk);
        #1;
    endtask
    task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", name, act, expv);
        end
    endtask
    function automatic logic [7:0] fb(int seed, int i, logic [15:0] et);
        return i == 20 ? et[15:8] : i == 21 ? et[7:0] : 8'(seed * 37 + i * 11 + 3);
    endfunction
    task automatic send(int seed, int len, logic [15:0] et, bit pass, int er_at, int tog_at);
        exp_t e;
        for (int i = 0; i < len; i++) begin
            up.data = fb(seed, i, et);
            up.dv = 1'b1;
            up.er = (i == er_at);
            if (i == tog_at) select = ~select;
            e.data = up.data;
            e.er = up.er;
            e.cyc = cyc + 1;
            if (pass) exp_q.push_back(e);
            step;
        end
        up.dv = 1'b0;
        up.er = 1'b0;
        up.data = 8'h00;
    endtask
    task automatic replay(int seed, int len, int first);
        exp_t e;
        for (int r = 0; r < REP; r++)
            for (int i = 0; i < len; i++) begin
                e.data = fb(seed, i, 16'h0806);
                e.er = 1'b0;
                e.cyc = first + r * (len + IFG + 2) + i;
                exp_q.push_back(e);
            end
    endtask
    task automatic wait_done(int expc, string name);
        int n = 0;
        while (replay_done !== 1'b1 && n < 3000) begin
            step;
            n++;
        end
        chk(name, cyc, expc);
    endtask
    initial begin
        up.data = 8'h00;
        up.dv = 1'b0;
        up.er = 1'b0;
        repeat (3) step;
        chk("rst_down_dv", down.dv, 0);
        chk("rst_down_data", down.data, 0);
        chk("rst_down_er", down.er, 0);
        chk("rst_busy", busy, 0);
        chk("rst_captured", captured, 0);
        chk("rst_replay_done", replay_done, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        rst = 1'b0;
        repeat (2) step;
        // basic capture and burst on select edge
        send(1, 60, 16'h0806, 1, -1, -1);
        repeat (2) step;
        chk("t1_captured", captured, 1);
        select = ~select;
        k = cyc;
        step;
        s = k + 4;
        replay(1, 60, s);
        step;
        chk("t1_busy", busy, 1);
        wait_done(s - 2 + REP * (60 + IFG + 2), "t1_done_cycle");
        step;
        chk("t1_done_pulse", replay_done, 0);
        step;
        chk("t1_busy_after", busy, 0);
        // non-ARP frame never commits; pending waits for a later ARP frame
        rst = 1'b1;
        repeat (2) step;
        rst = 1'b0;
        step;
        send(2, 60, 16'h0800, 1, -1, -1);
        step;
        chk("t2_captured", captured, 0);
        select = ~select;
        step;
        repeat (150) step;
        chk("t2_busy", busy, 0);
        send(3, 30, 16'h0800, 1, -1, -1);
        step;
        send(4, 40, 16'h0806, 1, -1, -1);
        s = cyc + 4;
        replay(4, 40, s);
        wait_done(s - 2 + REP * (40 + IFG + 2), "t2_done_cycle");
        repeat (3) step;
        // oversize and errored ARP frames leave the old capture in place
        send(5, DEPTH + 1, 16'h0806, 1, -1, -1);
        step;
        send(6, 60, 16'h0806, 1, 30, -1);
        step;
        trig = 1'b1;
        k = cyc;
        step;
        trig = 1'b0;
        s = k + 4;
        replay(4, 40, s);
        wait_done(s - 2 + REP * (40 + IFG + 2), "t3_done_cycle");
        repeat (3) step;
        send(7, DEPTH, 16'h0806, 1, -1, -1);
        step;
        trig = 1'b1;
        k = cyc;
        step;
        trig = 1'b0;
        s = k + 4;
        replay(7, DEPTH, s);
        wait_done(s - 2 + REP * (DEPTH + IFG + 2), "t3_full_done_cycle");
        repeat (3) step;
        // switch mid-frame: frame completes, burst starts 3 cycles after dv falls
        send(8, 100, 16'h0806, 1, -1, 10);
        s = cyc + 3;
        replay(7, DEPTH, s);
        wait_done(s - 2 + REP * (DEPTH + IFG + 2), "t4_done_cycle");
        repeat (3) step;
        // drops during a burst and a re-armed burst from a GAP event
        chk("t5_drop_before", drop_cnt, 0);
        trig = 1'b1;
        k = cyc;
        step;
        trig = 1'b0;
        s = k + 4;
        replay(7, DEPTH, s);
        repeat (10) step;
        send(9, 20, 16'h0800, 0, -1, -1);
        while (cyc < s + 140) step;
        send(10, 20, 16'h0800, 0, -1, -1);
        while (cyc < s + 458) step;
        select = ~select;
        step;
        d1 = s - 2 + REP * (DEPTH + IFG + 2);
        s2 = d1 + 4;
        replay(7, DEPTH, s2);
        wait_done(d1, "t5_done1_cycle");
        step;
        wait_done(s2 - 2 + REP * (DEPTH + IFG + 2), "t5_done2_cycle");
        chk("t5_drop_cnt", drop_cnt, 2);
        repeat (3) step;
        // reset during the second replayed frame
        trig = 1'b1;
        k = cyc;
        step;
        trig = 1'b0;
        s = k + 4;
        replay(7, DEPTH, s);
        while (cyc < s + 300) step;
        rst = 1'b1;
        step;
        exp_q.delete();
        chk("t6_down_dv", down.dv, 0);
        chk("t6_busy", busy, 0);
        chk("t6_captured", captured, 0);
        chk("t6_drop_cnt", drop_cnt, 0);
        rst = 1'b0;
        repeat (20) step;
        chk("t6_busy_after", busy, 0);
        chk("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
